// File: rtl/golden_nonce_reporter_if.sv
// Golden-nonce report bus: nonce/work strobes from the hashing core and the
// host toggle handshake from the JTAG side.
interface golden_nonce_reporter_if #(
  parameter int WORK_ID_W = 4
);
  logic                  rx_new_nonce;
  logic [31:0]           rx_nonce;
  logic                  rx_new_work;
  logic                  host_rd_toggle;
  logic [32+WORK_ID_W:0] rd_data;
  logic                  rd_ack_toggle;

  modport master (
    output rx_new_nonce, rx_nonce, rx_new_work, host_rd_toggle,
    input  rd_data, rd_ack_toggle
  );

  modport slave (
    input  rx_new_nonce, rx_nonce, rx_new_work, host_rd_toggle,
    output rd_data, rd_ack_toggle
  );
endinterface

// File: rtl/golden_nonce_reporter.sv
// Buffers work-tagged golden nonces in a FIFO and drains them to the host via a
// toggle req/ack handshake. Optional macro NONCE_DEDUP_EN drops repeated reports.
module golden_nonce_reporter #(
  parameter int DEPTH         = 8,
  parameter int WORK_ID_W     = 4,
  parameter int FLUSH_ON_WORK = 1
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  golden_nonce_reporter_if.slave   nonce_bus,
  output logic [7:0]               o_overflow_count,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 32 + WORK_ID_W;

  logic [EW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [WORK_ID_W-1:0] r_work_id;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic                 r_pop_d;
  logic                 r_ack;
  logic [EW:0]          r_rd_data;
  logic [7:0]           r_ovf;

  logic [PW-1:0] w_level;
  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_dup;
  logic          w_push_try;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_entry;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == PW'(DEPTH));
  assign w_flush    = (FLUSH_ON_WORK != 0) && nonce_bus.rx_new_work;
  assign w_pop_req  = r_sync2 ^ r_prev;
  assign w_pop      = w_pop_req && !w_empty && !w_flush;
  assign w_entry    = {r_work_id, nonce_bus.rx_nonce};
  assign w_push_try = nonce_bus.rx_new_nonce && !w_flush && !w_dup;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push     = w_push_try && (!w_full || w_pop);
  assign w_drop     = w_push_try && w_full && !w_pop;

`ifdef NONCE_DEDUP_EN
  logic [EW-1:0] r_last;
  logic          r_last_vld;

  assign w_dup = r_last_vld && (r_last == w_entry);

  always_ff @(posedge hash_clk) begin
    if (reset || nonce_bus.rx_new_work) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last     <= w_entry;
      r_last_vld <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge hash_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_work_id <= '0;
      // Preload with the live toggle level so a held level is not seen as a request.
      r_sync1   <= nonce_bus.host_rd_toggle;
      r_sync2   <= nonce_bus.host_rd_toggle;
      r_prev    <= nonce_bus.host_rd_toggle;
      r_pop_d   <= 1'b0;
      r_ack     <= 1'b0;
      r_rd_data <= '0;
      r_ovf     <= '0;
    end else begin
      r_sync1 <= nonce_bus.host_rd_toggle;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pop_d <= w_pop_req;
      if (r_pop_d) r_ack <= ~r_ack;
      if (w_pop_req) r_rd_data <= w_pop ? {1'b1, r_mem[r_rd_ptr[AW-1:0]]} : '0;
      if (nonce_bus.rx_new_work) r_work_id <= r_work_id + 1'b1;
      if (w_flush) r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 1'b1;
    end
  end

  assign nonce_bus.rd_data       = r_rd_data;
  assign nonce_bus.rd_ack_toggle = r_ack;
  assign o_overflow_count        = r_ovf;
  assign o_fifo_level            = w_level;
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed scoreboard bench for golden_nonce_reporter (DEPTH=8, WORK_ID_W=4,
// FLUSH_ON_WORK=1); dedup expectations follow NONCE_DEDUP_EN.
module tb_golden_nonce_reporter;
  logic       hash_clk;
  logic       reset;
  logic [7:0] ovf;
  logic [3:0] level;
  int         total = 0;
  int         bad   = 0;
  logic [36:0] exp_q[$];

  golden_nonce_reporter_if #(.WORK_ID_W(4)) u_bus ();

  golden_nonce_reporter #(
    .DEPTH(8), .WORK_ID_W(4), .FLUSH_ON_WORK(1)
  ) dut (
    .hash_clk         (hash_clk),
    .reset            (reset),
    .nonce_bus        (u_bus),
    .o_overflow_count (ovf),
    .o_fifo_level     (level)
  );

  initial begin
    hash_clk = 1'b0;
    forever #5 hash_clk = ~hash_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack level change presents one rd_data result.
  initial begin
    logic       prev_ack;
    logic [36:0] e;
    prev_ack = 1'b0;
    forever begin
      @(negedge hash_clk);
      if (reset) prev_ack = u_bus.rd_ack_toggle;
      else if (u_bus.rd_ack_toggle !== prev_ack) begin
        prev_ack = u_bus.rd_ack_toggle;
        if (exp_q.size() == 0) check("unexpected_ack", 64'(u_bus.rd_data), 64'h0DEAD);
        else begin
          e = exp_q.pop_front();
          check("rd_data", 64'(u_bus.rd_data), 64'(e));
        end
      end
    end
  end

  task automatic push(input logic [31:0] v);
    u_bus.rx_new_nonce = 1'b1;
    u_bus.rx_nonce     = v;
    @(negedge hash_clk);
    u_bus.rx_new_nonce = 1'b0;
  endtask

  // Toggle once and wait for the ack; optionally push on the pop cycle (edge 3).
  task automatic host_pop(input logic [36:0] exp, input bit with_push, input logic [31:0] pv);
    int   n;
    logic a0;
    a0 = u_bus.rd_ack_toggle;
    exp_q.push_back(exp);
    u_bus.host_rd_toggle = ~u_bus.host_rd_toggle;
    n = 0;
    while ((u_bus.rd_ack_toggle === a0) && (n < 20)) begin
      u_bus.rx_new_nonce = with_push && (n == 2);
      u_bus.rx_nonce     = pv;
      @(negedge hash_clk);
      n++;
    end
    u_bus.rx_new_nonce = 1'b0;
    check("ack_latency", 64'(n), 64'd4);
  endtask

  initial begin
    reset = 1'b1;
    u_bus.rx_new_nonce   = 1'b0;
    u_bus.rx_nonce       = '0;
    u_bus.rx_new_work    = 1'b0;
    u_bus.host_rd_toggle = 1'b0;
    repeat (3) @(negedge hash_clk);
    reset = 1'b0;
    check("rst_rd_data", 64'(u_bus.rd_data), 64'd0);
    check("rst_ack", 64'(u_bus.rd_ack_toggle), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    // single hit
    push(32'hDEADBEEF);
    check("t1_level_1", 64'(level), 64'd1);
    host_pop({1'b1, 4'h0, 32'hDEADBEEF}, 1'b0, '0);
    check("t1_level_0", 64'(level), 64'd0);

    // overflow then drain in order
    for (int i = 1; i <= 10; i++) push(32'(i));
    check("t2_level", 64'(level), 64'd8);
    check("t2_ovf", 64'(ovf), 64'd2);
    for (int i = 1; i <= 8; i++) host_pop({1'b1, 4'h0, 32'(i)}, 1'b0, '0);
    host_pop(37'd0, 1'b0, '0);
    check("t2_level_end", 64'(level), 64'd0);

    // work tag and flush
    push(32'h0000000A);
    u_bus.rx_new_work  = 1'b1;
    u_bus.rx_new_nonce = 1'b1;
    u_bus.rx_nonce     = 32'h0000000B;
    @(negedge hash_clk);
    u_bus.rx_new_work  = 1'b0;
    u_bus.rx_new_nonce = 1'b0;
    check("t3_flushed_level", 64'(level), 64'd0);
    check("t3_flush_no_ovf", 64'(ovf), 64'd2);
    host_pop(37'd0, 1'b0, '0);
    push(32'h0000000C);
    host_pop({1'b1, 4'h1, 32'h0000000C}, 1'b0, '0);

    // same-cycle push and pop on a full FIFO
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
    check("t4_full", 64'(level), 64'd8);
    host_pop({1'b1, 4'h1, 32'h100}, 1'b1, 32'h1FF);
    check("t4_level", 64'(level), 64'd8);
    check("t4_ovf", 64'(ovf), 64'd2);
    for (int i = 1; i < 8; i++) host_pop({1'b1, 4'h1, 32'h100 + 32'(i)}, 1'b0, '0);
    host_pop({1'b1, 4'h1, 32'h1FF}, 1'b0, '0);

    // dedup
    push(32'h12345678);
    push(32'h12345678);
`ifdef NONCE_DEDUP_EN
    check("t5_dup_level", 64'(level), 64'd1);
`else
    check("t5_dup_level", 64'(level), 64'd2);
`endif
    u_bus.rx_new_work = 1'b1;
    @(negedge hash_clk);
    u_bus.rx_new_work = 1'b0;
    check("t5_flush", 64'(level), 64'd0);
    push(32'h12345678);
    check("t5_after_work", 64'(level), 64'd1);
    host_pop({1'b1, 4'h2, 32'h12345678}, 1'b0, '0);

    // same-cycle push and pop on an empty FIFO: no bypass
    host_pop(37'd0, 1'b1, 32'h55);
    check("t7_level", 64'(level), 64'd1);
    host_pop({1'b1, 4'h2, 32'h55}, 1'b0, '0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) push(32'h61 + 32'(i));
    check("t6_level_3", 64'(level), 64'd3);
    u_bus.host_rd_toggle = ~u_bus.host_rd_toggle;
    @(negedge hash_clk);
    reset = 1'b1;
    repeat (2) @(negedge hash_clk);
    reset = 1'b0;
    check("t6_rd_data", 64'(u_bus.rd_data), 64'd0);
    check("t6_ack", 64'(u_bus.rd_ack_toggle), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    repeat (6) @(negedge hash_clk);
    check("t6_no_ack_flip", 64'(u_bus.rd_ack_toggle), 64'd0);
    host_pop(37'd0, 1'b0, '0);
    check("t6_rd_after", 64'(u_bus.rd_data), 64'd0);

    repeat (2) @(negedge hash_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
